// File: rtl/alu.sv
// Per-lane arithmetic unit: unsigned ADD/SUB/MUL/DIV on two operands, with the
// result and its NZP condition code registered for write-back and branching.
// Outputs only move on a clock edge where the lane is enabled and the core is
// in its execute state; there is no handshake, the operands are simply
// sampled at that edge and the result appears one clock later.
module alu #(
    parameter int         DATA_WIDTH    = 8,
    parameter logic [2:0] EXECUTE_STATE = 3'b101
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    input  logic [1:0]            alu_select,
    input  logic [2:0]            core_state,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic [2:0]            alu_nzp
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Condition-code encodings, bit2 = P, bit1 = Z, bit0 = N.
    localparam logic [2:0] NZP_POS  = 3'b100;
    localparam logic [2:0] NZP_ZERO = 3'b010;
    localparam logic [2:0] NZP_NEG  = 3'b001;

    logic [DATA_WIDTH-1:0] alu_out_q, alu_out_d;
    logic [2:0]            alu_nzp_q, alu_nzp_d;
    logic                  update_en;

    // Restoring long division, one quotient bit per iteration, MSB first.
    // A zero divisor yields a zero quotient rather than all ones.
    function automatic logic [DATA_WIDTH-1:0] udiv(
        input logic [DATA_WIDTH-1:0] num,
        input logic [DATA_WIDTH-1:0] den
    );
        logic [DATA_WIDTH:0]   rem;
        logic [DATA_WIDTH-1:0] quo;
        rem = '0;
        quo = '0;
        if (den != '0) begin
            for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
                rem = {rem[DATA_WIDTH-1:0], num[i]};
                if (rem >= {1'b0, den}) begin
                    rem    = rem - {1'b0, den};
                    quo[i] = 1'b1;
                end
            end
        end
        return quo;
    endfunction

    // The lane only computes when it is enabled and the scheduler is executing.
    assign update_en = enable && (core_state == EXECUTE_STATE);

    // Next result: every operation wraps modulo 2^DATA_WIDTH.
    always_comb begin
        alu_out_d = '0;
        unique case (alu_select)
            OP_ADD: alu_out_d = operand_1 + operand_2;
            OP_SUB: alu_out_d = operand_1 - operand_2;
            OP_MUL: alu_out_d = operand_1 * operand_2;
            OP_DIV: alu_out_d = udiv(operand_1, operand_2);
            default: alu_out_d = '0;
        endcase
    end

    // Next condition code, reading the new result as two's complement.
    always_comb begin
        alu_nzp_d = NZP_POS;
        if (alu_out_d == '0) begin
            alu_nzp_d = NZP_ZERO;
        end else if (alu_out_d[DATA_WIDTH-1]) begin
            alu_nzp_d = NZP_NEG;
        end
    end

    // Result and condition code load together, so NZP always matches alu_out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_out_q <= '0;
            alu_nzp_q <= 3'b000;
        end else if (update_en) begin
            alu_out_q <= alu_out_d;
            alu_nzp_q <= alu_nzp_d;
        end
    end

    assign alu_out = alu_out_q;
    assign alu_nzp = alu_nzp_q;

endmodule

// File: tb/tb_alu.sv
// Bench for the lane ALU. A driver pushes the model's expected {nzp, out} into
// a queue whenever it presents a qualifying operation; each scenario task pops
// and compares after the following clock edge.
module tb_alu;

    localparam int         W    = 8;
    localparam logic [2:0] EXEC = 3'b101;

    logic         clock;
    logic         reset;
    logic         enable;
    logic [W-1:0] operand_1;
    logic [W-1:0] operand_2;
    logic [1:0]   alu_select;
    logic [2:0]   core_state;
    logic [W-1:0] alu_out;
    logic [2:0]   alu_nzp;

    alu #(.DATA_WIDTH(W), .EXECUTE_STATE(EXEC)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .alu_select (alu_select),
        .core_state (core_state),
        .alu_out    (alu_out),
        .alu_nzp    (alu_nzp)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: entries are {nzp[2:0], out[7:0]}
    logic [W+2:0] exp_q[$];
    logic [W+2:0] last_exp;
    logic [W+2:0] got;
    logic [W+2:0] exp;
    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sel;
    } vec_t;

    // 0-1 add/sub, 2-4 mul/div, 5-8 wrap and sign
    vec_t vecs [0:8] = '{
        '{8'd25,  8'd11,  2'b00},
        '{8'd25,  8'd11,  2'b01},
        '{8'd5,   8'd11,  2'b10},
        '{8'd11,  8'd5,   2'b11},
        '{8'd16,  8'd16,  2'b10},
        '{8'd5,   8'd11,  2'b01},
        '{8'd200, 8'd100, 2'b00},
        '{8'd7,   8'd7,   2'b01},
        '{8'd9,   8'd0,   2'b11}
    };

    // Reference model with plain integer arithmetic
    function automatic logic [W+2:0] model(input int a, input int b, input logic [1:0] sel);
        int r;
        logic [2:0] nzp;
        case (sel)
            2'b00:   r = (a + b) % 256;
            2'b01:   r = (a - b + 256) % 256;
            2'b10:   r = (a * b) % 256;
            default: r = (b == 0) ? 0 : a / b;
        endcase
        if (r == 0)        nzp = 3'b010;
        else if (r >= 128) nzp = 3'b001;
        else               nzp = 3'b100;
        return {nzp, r[7:0]};
    endfunction

    // Driver: present a qualifying operation at the falling edge
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
        @(negedge clock);
        operand_1  = a;
        operand_2  = b;
        alu_select = sel;
        enable     = 1'b1;
        core_state = EXEC;
        last_exp   = model(int'(a), int'(b), sel);
        exp_q.push_back(last_exp);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        enable     = 1'b0;
        operand_1  = '0;
        operand_2  = '0;
        alu_select = 2'b00;
        core_state = 3'b000;
        last_exp   = '0;
        #1;
        n_cmp++;
        if ({alu_nzp, alu_out} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_init: got out=%0d nzp=%b, want out=0 nzp=000", alu_out, alu_nzp);
        end
        // Qualifying inputs during reset must not load anything
        enable     = 1'b1;
        core_state = EXEC;
        operand_1  = 8'd3;
        operand_2  = 8'd4;
        @(posedge clock); #1;
        n_cmp++;
        if ({alu_nzp, alu_out} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got out=%0d nzp=%b, want out=0 nzp=000", alu_out, alu_nzp);
        end
        @(negedge clock);
        enable = 1'b0;
        reset  = 1'b1;
    endtask

    task automatic test_add_sub();
        for (int i = 0; i < 2; i++) begin
            drive_op(vecs[i].a, vecs[i].b, vecs[i].sel);
            @(posedge clock); #1;
            got = {alu_nzp, alu_out};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL add_sub[%0d]: scoreboard empty", i);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL add_sub[%0d]: got out=%0d nzp=%b, want out=%0d nzp=%b",
                             i, got[7:0], got[10:8], exp[7:0], exp[10:8]);
                end
            end
        end
    endtask

    task automatic test_mul_div();
        for (int i = 2; i < 5; i++) begin
            drive_op(vecs[i].a, vecs[i].b, vecs[i].sel);
            @(posedge clock); #1;
            got = {alu_nzp, alu_out};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mul_div[%0d]: scoreboard empty", i);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL mul_div[%0d]: got out=%0d nzp=%b, want out=%0d nzp=%b",
                             i, got[7:0], got[10:8], exp[7:0], exp[10:8]);
                end
            end
        end
    endtask

    task automatic test_wrap_sign();
        for (int i = 5; i < 9; i++) begin
            drive_op(vecs[i].a, vecs[i].b, vecs[i].sel);
            @(posedge clock); #1;
            got = {alu_nzp, alu_out};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wrap_sign[%0d]: scoreboard empty", i);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL wrap_sign[%0d]: got out=%0d nzp=%b, want out=%0d nzp=%b",
                             i, got[7:0], got[10:8], exp[7:0], exp[10:8]);
                end
            end
        end
    endtask

    task automatic test_hold();
        // Step 0 loads 25+11; steps 1-2 must hold it; step 3 takes 99+1
        for (int step = 0; step < 4; step++) begin
            case (step)
                0: drive_op(8'd25, 8'd11, 2'b00);
                1: begin
                    @(negedge clock);
                    enable     = 1'b0;
                    operand_1  = 8'd99;
                    operand_2  = 8'd1;
                    alu_select = 2'b00;
                    exp_q.push_back(last_exp);
                end
                2: begin
                    @(negedge clock);
                    enable     = 1'b1;
                    core_state = 3'b011;
                    exp_q.push_back(last_exp);
                end
                default: drive_op(8'd99, 8'd1, 2'b00);
            endcase
            @(posedge clock); #1;
            got = {alu_nzp, alu_out};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL hold[%0d]: scoreboard empty", step);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL hold[%0d]: got out=%0d nzp=%b, want out=%0d nzp=%b",
                             step, got[7:0], got[10:8], exp[7:0], exp[10:8]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sel;
        for (int i = 0; i < 40; i++) begin
            a   = 8'($urandom_range(0, 255));
            b   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            sel = 2'($urandom_range(0, 3));
            drive_op(a, b, sel);
            @(posedge clock); #1;
            got = {alu_nzp, alu_out};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b[%0d]: scoreboard empty", i);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL b2b[%0d] a=%0d b=%0d sel=%b: got out=%0d nzp=%b, want out=%0d nzp=%b",
                             i, a, b, sel, got[7:0], got[10:8], exp[7:0], exp[10:8]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        drive_op(8'd25, 8'd11, 2'b00);
        @(posedge clock); #1;
        exp = exp_q.pop_front();
        n_cmp++;
        if ({alu_nzp, alu_out} !== exp) begin
            n_fail++;
            $display("FAIL rst_mid_load: got out=%0d nzp=%b, want out=%0d nzp=%b",
                     alu_out, alu_nzp, exp[7:0], exp[10:8]);
        end
        // New operation presented, then reset drops before its edge
        @(negedge clock);
        operand_1  = 8'd100;
        operand_2  = 8'd2;
        alu_select = 2'b10;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({alu_nzp, alu_out} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_async: got out=%0d nzp=%b, want out=0 nzp=000", alu_out, alu_nzp);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            n_cmp++;
            if ({alu_nzp, alu_out} !== 11'd0) begin
                n_fail++;
                $display("FAIL rst_held[%0d]: got out=%0d nzp=%b, want out=0 nzp=000", i, alu_out, alu_nzp);
            end
        end
        @(negedge clock);
        enable = 1'b0;
        reset  = 1'b1;
        last_exp = '0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_add_sub();
        test_mul_div();
        test_wrap_sign();
        test_hold();
        test_back_to_back();
        test_reset_mid_op();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d queued entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
